// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared constants and state encoding for the memory port arbiter
//   RstEnable  : active level of rst
//   ZeroWord   : 32-bit zero word
//   Stall*     : stall vectors, bit 0 PC .. bit 5 WB
//   state_e    : arbiter FSM states
package mem_port_arbiter_pkg;
   localparam logic        RstEnable = 1'b1;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;
   localparam logic [5:0]  StallNone = 6'b000000;
   localparam logic [5:0]  StallIF   = 6'b000011;
   localparam logic [5:0]  StallID   = 6'b000111;
   localparam logic [5:0]  StallMEM  = 6'b011111;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_MEM = 2'd2
   } state_e;
endpackage

// File: rtl/mem_port_arbiter_stall_gen.sv
// mem_port_arbiter_stall_gen: pipeline stall priority and deferred flush
//   clk, rst        : clock, asynchronous active-high reset
//   mem_req_i/ack_i : load/store request and its registered completion
//   if_req_i/ack_i  : fetch request and its registered completion
//   id_stallreq_i   : load-use hazard from decode
//   ex_flush_i      : taken branch/jump pulse from EX
//   stall_o         : stall vector (MEM > ID > IF)
//   flush_o         : squash IF/ID and ID/EX
module mem_port_arbiter_stall_gen
   import mem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_req_i,
   input  logic       mem_ack_i,
   input  logic       if_req_i,
   input  logic       if_ack_i,
   input  logic       id_stallreq_i,
   input  logic       ex_flush_i,
   output logic [5:0] stall_o,
   output logic       flush_o
);
   logic mem_stall;
   logic flush_q, flush_d, flush_pend_q, flush_pend_d;
   assign mem_stall = mem_req_i & ~mem_ack_i;
   // A flush raised while MEM holds the pipeline is parked and released
   // combinationally on the first cycle the MEM stall is gone.
   always_comb begin
      stall_o      = (rst == RstEnable) ? StallNone :
                     mem_stall ? StallMEM :
                     id_stallreq_i ? StallID :
                     (if_req_i & ~if_ack_i) ? StallIF : StallNone;
      flush_d      = ex_flush_i & ~mem_stall;
      flush_pend_d = mem_stall & (flush_pend_q | ex_flush_i);
      flush_o      = flush_q | (flush_pend_q & ~mem_stall);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         flush_q      <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         flush_q      <= flush_d;
         flush_pend_q <= flush_pend_d;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (MEM)
//   clk, rst          : clock, asynchronous active-high reset
//   if_*              : fetch requester (req level, addr, rdata, one-cycle ack)
//   mem_*             : load/store requester (req, we, addr, wdata, sel, rdata, ack)
//   bus_*             : memory port (req, we, addr, wdata, sel, rdata, ack)
//   id_stallreq_i     : load-use hazard, ex_flush_i : branch/jump flush pulse
//   stall_o, flush_o  : pipeline register control
//   bus_err_o         : timeout pulse, present only with MEM_PORT_TIMEOUT_EN
// Optional macro MEM_PORT_TIMEOUT_EN adds a bus-wait timeout (TIMEOUT_CYC).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_PORT_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_ack_o,
   input  logic                mem_req_i,
   input  logic                mem_we_i,
   input  logic [ADDR_W-1:0]   mem_addr_i,
   input  logic [DATA_W-1:0]   mem_wdata_i,
   input  logic [DATA_W/8-1:0] mem_sel_i,
   output logic [DATA_W-1:0]   mem_rdata_o,
   output logic                mem_ack_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   output logic [DATA_W/8-1:0] bus_sel_o,
   input  logic [DATA_W-1:0]   bus_rdata_i,
   input  logic                bus_ack_i,
   input  logic                id_stallreq_i,
   input  logic                ex_flush_i,
   output logic [5:0]          stall_o,
`ifdef MEM_PORT_TIMEOUT_EN
   output logic                flush_o,
   output logic                bus_err_o
`else
   output logic                flush_o
`endif
);
   localparam int SEL_W = DATA_W / 8;
   state_e              state_q, state_d;
   logic                bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
   logic                if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
   logic                fetch_kill_q, fetch_kill_d;
   logic                idle, in_if, in_mem, grant_mem, grant_if, load_mem, load_if;
   logic                timeout, done, kill_now;
   logic [DATA_W-1:0]   rdata_w;
   assign in_if  = (state_q == GNT_IF);
   assign in_mem = (state_q == GNT_MEM);
   assign idle   = ~(in_if | in_mem);
   // A requester still shows its level request in its own ack cycle; the
   // registered ack masks it so a finished request is not granted again.
   assign grant_mem = mem_req_i & ~mem_ack_q;
   assign grant_if  = if_req_i & ~if_ack_q & ~fetch_kill_q;
   assign done      = bus_ack_i | timeout;
`ifdef MEM_PORT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bus_err_q;
   assign timeout = ~idle & ~bus_ack_i & (cnt_q == CW'(TIMEOUT_CYC - 1));
   assign cnt_d   = (idle | done) ? '0 : cnt_q + CW'(1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= timeout;
      end
   end
   assign bus_err_o = bus_err_q;
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q      <= IDLE;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_sel_q    <= '0;
         if_ack_q     <= 1'b0;
         mem_ack_q    <= 1'b0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         fetch_kill_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_sel_q    <= bus_sel_d;
         if_ack_q     <= if_ack_d;
         mem_ack_q    <= mem_ack_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         fetch_kill_q <= fetch_kill_d;
      end
   end
   always_comb begin
      state_d = idle ? (grant_mem ? GNT_MEM : grant_if ? GNT_IF : IDLE) :
                done ? IDLE : state_q;
   end
   // Fetches overtaken by a flush still finish on the bus, but their word is
   // dropped: no if_ack and if_rdata keeps its previous value.
   always_comb begin
      load_mem     = idle & grant_mem;
      load_if      = idle & ~grant_mem & grant_if;
      kill_now     = in_if & (ex_flush_i | flush_o);
      rdata_w      = timeout ? '1 : bus_rdata_i;
      bus_req_d    = idle ? (load_mem | load_if) : ~done;
      bus_we_d     = load_mem ? mem_we_i : load_if ? 1'b0 : bus_we_q;
      bus_addr_d   = load_mem ? mem_addr_i : load_if ? if_addr_i : bus_addr_q;
      bus_wdata_d  = load_mem ? mem_wdata_i : bus_wdata_q;
      bus_sel_d    = load_mem ? mem_sel_i : load_if ? '1 : bus_sel_q;
      if_ack_d     = in_if & done & ~fetch_kill_q & ~kill_now;
      mem_ack_d    = in_mem & done;
      if_rdata_d   = if_ack_d ? rdata_w : if_rdata_q;
      mem_rdata_d  = mem_ack_d ? rdata_w : mem_rdata_q;
      fetch_kill_d = in_if & ~done & (fetch_kill_q | kill_now);
   end
   mem_port_arbiter_stall_gen u_stall_gen (
      .clk          (clk),
      .rst          (rst),
      .mem_req_i    (mem_req_i),
      .mem_ack_i    (mem_ack_q),
      .if_req_i     (if_req_i),
      .if_ack_i     (if_ack_q),
      .id_stallreq_i(id_stallreq_i),
      .ex_flush_i   (ex_flush_i),
      .stall_o      (stall_o),
      .flush_o      (flush_o)
   );
   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_sel_o   = bus_sel_q;
   assign if_ack_o    = if_ack_q;
   assign mem_ack_o   = mem_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign mem_rdata_o = mem_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port arbiter
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we, bus_ack, id_stallreq, ex_flush;
   logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
   logic [3:0]  mem_sel;
   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
   logic        if_ack, mem_ack, bus_req, bus_we, flush;
   logic [3:0]  bus_sel;
   logic [5:0]  stall;
   logic        bus_err;
   int checks = 0, errors = 0;
   logic [31:0] sl_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int  fixed_lat = 0, cur_lat = 0, wait_cnt = 0;
   bit  no_ack = 0;
   logic [31:0] exp_if_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef MEM_PORT_TIMEOUT_EN
      , .TIMEOUT_CYC(4)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_sel_i(mem_sel), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_sel_o(bus_sel), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
      .id_stallreq_i(id_stallreq), .ex_flush_i(ex_flush), .stall_o(stall),
`ifdef MEM_PORT_TIMEOUT_EN
      .flush_o(flush), .bus_err_o(bus_err)
`else
      .flush_o(flush)
`endif
   );
`ifndef MEM_PORT_TIMEOUT_EN
   assign bus_err = 1'b0;
`endif

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
      logic [31:0] r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction
   function automatic logic [31:0] sl_rd(input logic [31:0] a);
      return sl_mem.exists(a) ? sl_mem[a] : init_word(a);
   endfunction
   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic set_lat(input int l);
      fixed_lat = l;
      cur_lat   = (l >= 0) ? l : int'($urandom_range(0, 3));
   endtask

   // Memory slave: acks cur_lat cycles after it first sees bus_req.
   task automatic respond();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (bus_req && !no_ack) begin
         if (wait_cnt >= cur_lat) begin
            bus_ack   = 1'b1;
            bus_rdata = sl_rd(bus_addr);
            if (bus_we) sl_mem[bus_addr] = merge(sl_rd(bus_addr), bus_wdata, bus_sel);
            wait_cnt = 0;
            cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
         end else wait_cnt++;
      end else wait_cnt = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      respond();
   endtask

   task automatic clear_inputs();
      if_req = 0; mem_req = 0; mem_we = 0; id_stallreq = 0; ex_flush = 0;
      if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus_ack = 0; bus_rdata = 0;
      rst = 1;
      if_req = 1; mem_req = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
      checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b want 000000", stall); end
      checks++; if ({flush, if_ack, mem_ack, bus_we, bus_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {flush, if_ack, mem_ack, bus_we, bus_err}); end
      checks++; if ({bus_addr, bus_wdata, if_rdata, mem_rdata, bus_sel} !== 132'b0) begin errors++; $display("FAIL reset_data got %h %h %h %h %h want 0", bus_addr, bus_wdata, if_rdata, mem_rdata, bus_sel); end
      clear_inputs();
      rst = 0;
      exp_if_rdata = 0;
   endtask

   task automatic test_if_fetch();
      bit drop = 0;
      set_lat(3);
      sl_mem[32'h100] = 32'h00A0_0093;
      tick();
      if_req = 1; if_addr = 32'h100;
      @(negedge clk);
      checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL fetch_stall_req got %b want 000011", stall); end
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (drop) if_req = 0;
         @(negedge clk);
         if (n == 1) begin
            checks++; if (!bus_req || bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_sel !== 4'hF) begin errors++; $display("FAIL fetch_grant req %b addr %h we %b sel %h want 1 100 0 f", bus_req, bus_addr, bus_we, bus_sel); end
         end
         checks++; if (if_ack !== (n == 5)) begin errors++; $display("FAIL fetch_ack cycle %0d got %b want %b", n, if_ack, n == 5); end
         checks++; if (stall !== ((n < 5) ? 6'b000011 : 6'b000000)) begin errors++; $display("FAIL fetch_stall cycle %0d got %b", n, stall); end
         if (n >= 5) begin
            checks++; if (if_rdata !== 32'h00A0_0093) begin errors++; $display("FAIL fetch_rdata got %h want 00a00093", if_rdata); end
         end
         drop = if_ack;
      end
      exp_if_rdata = 32'h00A0_0093;
   endtask

   task automatic test_mem_priority();
      bit dm = 0, di = 0;
      set_lat(1);
      tick();
      if_req = 1; if_addr = 32'h104;
      mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
      @(negedge clk);
      checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_stall0 got %b want 011111", stall); end
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (dm) mem_req = 0;
         if (di) if_req = 0;
         @(negedge clk);
         if (n == 1) begin
            checks++; if (!bus_req || !bus_we || bus_addr !== 32'h2000 || bus_wdata !== 32'hDEAD_BEEF || bus_sel !== 4'hF) begin errors++; $display("FAIL prio_mem_first req %b we %b addr %h wdata %h sel %h", bus_req, bus_we, bus_addr, bus_wdata, bus_sel); end
         end
         if (n == 3) begin
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL prio_idle_gap got bus_req %b want 0", bus_req); end
         end
         if (n == 4) begin
            checks++; if (!bus_req || bus_we || bus_addr !== 32'h104) begin errors++; $display("FAIL prio_if_second req %b we %b addr %h want 1 0 104", bus_req, bus_we, bus_addr); end
         end
         checks++; if (mem_ack !== (n == 3) || if_ack !== (n == 6)) begin errors++; $display("FAIL prio_acks cycle %0d mem %b if %b", n, mem_ack, if_ack); end
         checks++; if (stall !== ((n < 3) ? 6'b011111 : (n < 6) ? 6'b000011 : 6'b000000)) begin errors++; $display("FAIL prio_stall cycle %0d got %b", n, stall); end
         if (n == 6) begin
            checks++; if (if_rdata !== init_word(32'h104)) begin errors++; $display("FAIL prio_if_rdata got %h want %h", if_rdata, init_word(32'h104)); end
         end
         dm = mem_ack; di = if_ack;
      end
      checks++; if (sl_rd(32'h2000) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_store got %h want deadbeef", sl_rd(32'h2000)); end
      mem_we = 0;
      exp_if_rdata = init_word(32'h104);
   endtask

   task automatic test_stall_priority();
      bit dm = 0;
      set_lat(2);
      tick();
      mem_req = 1; mem_we = 0; mem_addr = 32'h3000; id_stallreq = 1;
      for (int n = 1; n <= 6; n++) begin
         tick();
         if (dm) mem_req = 0;
         @(negedge clk);
         checks++; if (stall !== ((n < 4) ? 6'b011111 : 6'b000111)) begin errors++; $display("FAIL sprio_stall cycle %0d got %b", n, stall); end
         if (n == 4) begin
            checks++; if (!mem_ack || mem_rdata !== init_word(32'h3000)) begin errors++; $display("FAIL sprio_load ack %b rdata %h want 1 %h", mem_ack, mem_rdata, init_word(32'h3000)); end
         end
         dm = mem_ack;
      end
      id_stallreq = 0;
   endtask

   task automatic test_flush_pend();
      bit dm = 0;
      set_lat(2);
      tick();
      mem_req = 1; mem_we = 0; mem_addr = 32'h3004;
      for (int n = 1; n <= 7; n++) begin
         tick();
         if (dm) mem_req = 0;
         ex_flush = (n == 1);
         @(negedge clk);
         checks++; if (flush !== (n == 4)) begin errors++; $display("FAIL flush_pend cycle %0d got %b want %b", n, flush, n == 4); end
         dm = mem_ack;
      end
   endtask

   task automatic test_flush_no_stall();
      tick();
      ex_flush = 1;
      @(negedge clk);
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_same_cycle got %b want 0", flush); end
      tick();
      ex_flush = 0;
      @(negedge clk);
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flush_registered got %b want 1", flush); end
      tick();
      @(negedge clk);
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle got %b want 0", flush); end
   endtask

   task automatic test_fetch_kill();
      bit drop = 0;
      set_lat(3);
      sl_mem[32'h200] = 32'h1111_2222;
      sl_mem[32'h300] = 32'h3333_4444;
      tick();
      if_req = 1; if_addr = 32'h200;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (drop) if_req = 0;
         ex_flush = (n == 2);
         if (n == 3) if_addr = 32'h300;
         @(negedge clk);
         if (n == 1) begin
            checks++; if (!bus_req || bus_addr !== 32'h200) begin errors++; $display("FAIL kill_grant req %b addr %h want 1 200", bus_req, bus_addr); end
         end
         if (n == 3) begin
            checks++; if (flush !== 1'b1) begin errors++; $display("FAIL kill_flush got %b want 1", flush); end
         end
         if (n == 5) begin
            checks++; if (bus_req !== 1'b0 || if_rdata !== exp_if_rdata) begin errors++; $display("FAIL kill_drop bus_req %b if_rdata %h want 0 %h", bus_req, if_rdata, exp_if_rdata); end
         end
         if (n == 6) begin
            checks++; if (!bus_req || bus_addr !== 32'h300) begin errors++; $display("FAIL kill_refetch req %b addr %h want 1 300", bus_req, bus_addr); end
         end
         checks++; if (if_ack !== (n == 10)) begin errors++; $display("FAIL kill_ack cycle %0d got %b want %b", n, if_ack, n == 10); end
         if (n == 10) begin
            checks++; if (if_rdata !== 32'h3333_4444) begin errors++; $display("FAIL kill_rdata got %h want 33334444", if_rdata); end
         end
         drop = if_ack;
      end
      exp_if_rdata = 32'h3333_4444;
   endtask

   task automatic test_reset_mid();
      no_ack = 1;
      tick();
      mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
      tick();
      @(negedge clk);
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_granted got %b want 1", bus_req); end
      #2 rst = 1;
      #1;
      checks++; if (bus_req !== 1'b0 || stall !== 6'b0) begin errors++; $display("FAIL rmid_async bus_req %b stall %b want 0 000000", bus_req, stall); end
      @(negedge clk);
      clear_inputs();
      rst = 0;
      no_ack = 0;
      exp_if_rdata = 0;
   endtask

`ifdef MEM_PORT_TIMEOUT_EN
   task automatic test_timeout();
      bit dm = 0;
      no_ack = 1;
      tick();
      mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (dm) mem_req = 0;
         @(negedge clk);
         checks++; if (bus_req !== (n >= 1 && n <= 4)) begin errors++; $display("FAIL tmo_req cycle %0d got %b", n, bus_req); end
         checks++; if (bus_err !== (n == 5) || mem_ack !== (n == 5)) begin errors++; $display("FAIL tmo_err cycle %0d err %b ack %b", n, bus_err, mem_ack); end
         if (n == 5) begin
            checks++; if (mem_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_rdata got %h want ffffffff", mem_rdata); end
         end
         dm = mem_ack;
      end
      no_ack = 0;
   endtask
`endif

   task automatic test_random();
      bit if_out = 0, mem_out = 0;
      bit p_req = 0, p_back = 0, p_we = 0, p_mem_pend = 0;
      logic [31:0] p_addr = 0, p_wdata = 0;
      logic [3:0]  p_sel = 0;
      logic [5:0]  exp_st;
      int n_if = 0, n_if_done = 0, n_mem = 0, n_mem_done = 0;
      set_lat(-1);
      for (int c = 0; c < 3060; c++) begin
         tick();
         if (if_ack) begin
            checks++; if (!if_out || if_rdata !== init_word(if_addr)) begin errors++; $display("FAIL rnd_if_ack cycle %0d out %b rdata %h want %h", c, if_out, if_rdata, init_word(if_addr)); end
            if_out = 0; if_req = 0; n_if_done++;
         end else if (c < 3000 && !if_out && $urandom_range(0, 2) == 0) begin
            if_addr = 32'($urandom_range(0, 63)) << 2; if_req = 1; if_out = 1; n_if++;
         end
         if (mem_ack) begin
            if (mem_we) begin
               checks++; if (!mem_out) begin errors++; $display("FAIL rnd_store_ack cycle %0d spurious", c); end
               ref_mem[mem_addr] = merge(ref_rd(mem_addr), mem_wdata, mem_sel);
            end else begin
               checks++; if (!mem_out || mem_rdata !== ref_rd(mem_addr)) begin errors++; $display("FAIL rnd_load cycle %0d addr %h got %h want %h", c, mem_addr, mem_rdata, ref_rd(mem_addr)); end
            end
            mem_out = 0; mem_req = 0; n_mem_done++;
         end else if (c < 3000 && !mem_out && $urandom_range(0, 3) == 0) begin
            mem_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            mem_we = $urandom_range(0, 1) == 1; mem_wdata = $urandom; mem_sel = 4'($urandom_range(1, 15));
            mem_req = 1; mem_out = 1; n_mem++;
         end
         id_stallreq = (c < 3000) && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         exp_st = (mem_req && !mem_ack) ? 6'b011111 : id_stallreq ? 6'b000111 : (if_req && !if_ack) ? 6'b000011 : 6'b000000;
         checks++; if (stall !== exp_st) begin errors++; $display("FAIL rnd_stall cycle %0d got %b want %b", c, stall, exp_st); end
         checks++; if (if_ack && mem_ack) begin errors++; $display("FAIL rnd_dual_ack cycle %0d got 1 1", c); end
         if (p_req && bus_req) begin
            checks++; if (p_back || bus_addr !== p_addr || bus_we !== p_we || bus_wdata !== p_wdata || bus_sel !== p_sel) begin errors++; $display("FAIL rnd_hold cycle %0d addr %h want %h back %b", c, bus_addr, p_addr, p_back); end
         end
         if (bus_req && !p_req) begin
            checks++; if (bus_addr !== (p_mem_pend ? mem_addr : if_addr) || bus_we !== (p_mem_pend ? mem_we : 1'b0)) begin errors++; $display("FAIL rnd_grant cycle %0d addr %h mem_pend %b", c, bus_addr, p_mem_pend); end
         end
         p_req = bus_req; p_back = bus_ack; p_addr = bus_addr; p_we = bus_we; p_wdata = bus_wdata; p_sel = bus_sel;
         p_mem_pend = mem_req && !mem_ack;
      end
      checks++; if (n_if != n_if_done || n_mem != n_mem_done || if_out || mem_out) begin errors++; $display("FAIL rnd_complete if %0d/%0d mem %0d/%0d", n_if_done, n_if, n_mem_done, n_mem); end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_if_fetch();
      test_mem_priority();
      test_stall_priority();
      test_flush_pend();
      test_flush_no_stall();
      test_fetch_kill();
      test_reset_mid();
`ifdef MEM_PORT_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
